// File: rtl/int_ctrl_vec.sv
// int_ctrl_vec: parametrised vectored interrupt controller with nested preemption.
// Sources are latched, masked and prioritised (index 0 = highest). At an
// instruction boundary the winner gets a one-cycle registered take pulse with
// its vector address. The interrupted PC and prior active ID are pushed on an
// internal return stack, and a ret strobe pops them back.
// Optional build macro INT_CTRL_LEVEL_EN: when defined, sources are
// level-sensitive and pending mirrors irq_in. Otherwise, rising edges are
// latched and cleared when the source is serviced.
module int_ctrl_vec #(
  parameter int                NUM_SRC        = 8,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE       = 32'h0000_0040,
  parameter int                VEC_STRIDE     = 4,
  parameter int                NEST_DEPTH     = 4,
  parameter logic [2:0]        BOUNDARY_STATE = 3'd0,
  localparam int               DW             = $clog2(NEST_DEPTH + 1)
) (
  input  logic               clk_10hz,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic [2:0]         cpu_state,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               ret,
  output logic               take,
  output logic [ADDR_W-1:0]  vec_addr,
  output logic [ADDR_W-1:0]  epc_out,
  output logic [3:0]         active_id,
  output logic [DW-1:0]      depth,
  output logic [NUM_SRC-1:0] pending,
  output logic               ret_err
);

  // Stack index width: at least 1 bit so NEST_DEPTH=1 still gets a legal array.
  localparam int IW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ACK, RUN} state_e;

  state_e              state_q, state_d;
  logic                take_q, take_d;
  logic [ADDR_W-1:0]   vec_q, vec_d;
  logic [ADDR_W-1:0]   epc_q, epc_d;
  logic [3:0]          active_q, active_d;
  logic [3:0]          win_q, win_d;
  logic [DW-1:0]       depth_q, depth_d;
  logic                ret_err_q, ret_err_d;

  logic [NUM_SRC-1:0]  pend_view;
  logic [NUM_SRC-1:0]  eligible;
  logic [3:0]          winner;
  logic                has_win;
  logic                preempt;
  logic                push;

  logic [ADDR_W-1:0]   stk_pc_q [2**IW];
  logic [3:0]          stk_id_q [2**IW];
  logic [DW-1:0]       depth_m1;
  logic [IW-1:0]       push_idx, top_idx;

`ifdef INT_CTRL_LEVEL_EN
  // Level-sensitive sources: whatever is asserted right now is pending.
  assign pend_view = irq_in;
`else
  logic [NUM_SRC-1:0] irq_prev_q, pending_q, rise, ack_clr;

  assign rise    = irq_in & ~irq_prev_q;
  assign ack_clr = (state_q == ACK) ? (NUM_SRC'(1) << win_q) : '0;

  // Latch rising edges. A new edge on the serviced source beats its clear.
  always_ff @(posedge clk_10hz or posedge rst) begin
    if (rst) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      irq_prev_q <= irq_in;
      pending_q  <= (pending_q & ~ack_clr) | rise;
    end
  end

  assign pend_view = pending_q;
`endif

  assign eligible = pend_view & irq_mask;
  assign has_win  = |eligible;
  assign depth_m1 = depth_q - 1'b1;
  assign push_idx = depth_q[IW-1:0];
  assign top_idx  = depth_m1[IW-1:0];

  // Fixed priority: the lowest set index wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 4'(i);
    end
  end

  assign preempt = has_win
                && ((winner < active_q) || (depth_q == '0))
                && (depth_q < DW'(NEST_DEPTH))
                && (cpu_state == BOUNDARY_STATE)
                && (state_q != ACK)
                && !ret;

  // Next-state and register-update logic for the IDLE/ACK/RUN controller.
  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d   = state_q;
    take_d    = 1'b0;
    vec_d     = vec_q;
    epc_d     = epc_q;
    active_d  = active_q;
    win_d     = win_q;
    depth_d   = depth_q;
    ret_err_d = ret_err_q | (ret && (depth_q == '0));
    push      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (preempt) begin
          state_d = ACK;
          take_d  = 1'b1;
          win_d   = winner;
          vec_d   = VEC_BASE + ADDR_W'(winner) * ADDR_W'(VEC_STRIDE);
        end
      end
      ACK: begin
        push     = 1'b1;
        active_d = win_q;
        epc_d    = pc_in;
        depth_d  = depth_q + 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        if (ret && (depth_q != '0)) begin
          active_d = stk_id_q[top_idx];
          epc_d    = stk_pc_q[top_idx];
          depth_d  = depth_m1;
          if (depth_q == DW'(1)) state_d = IDLE;
        end else if (preempt) begin
          state_d = ACK;
          take_d  = 1'b1;
          win_d   = winner;
          vec_d   = VEC_BASE + ADDR_W'(winner) * ADDR_W'(VEC_STRIDE);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers. Reset drops any in-flight ACK and the take pulse at once.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_10hz or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      take_q    <= 1'b0;
      vec_q     <= '0;
      epc_q     <= '0;
      active_q  <= '0;
      win_q     <= '0;
      depth_q   <= '0;
      ret_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      take_q    <= take_d;
      vec_q     <= vec_d;
      epc_q     <= epc_d;
      active_q  <= active_d;
      win_q     <= win_d;
      depth_q   <= depth_d;
      ret_err_q <= ret_err_d;
    end
  end

  // Return stack storage, written in the ACK cycle.
  // NOTE: the stack array has no reset; depth_q=0 already marks every entry invalid.
  always_ff @(posedge clk_10hz) begin
    if (push) begin
      stk_pc_q[push_idx] <= pc_in;
      stk_id_q[push_idx] <= active_q;
    end
  end

  assign take      = take_q;
  assign vec_addr  = vec_q;
  assign epc_out   = epc_q;
  assign active_id = active_q;
  assign depth     = depth_q;
  assign pending   = pend_view;
  assign ret_err   = ret_err_q;

endmodule

// File: tb/tb_int_ctrl_vec.sv
// tb_int_ctrl_vec: directed bench for int_ctrl_vec with a queue-based reference
// model. The model is checked every cycle, and literal expectations pin the model.
// A second instance built with NEST_DEPTH=1 exercises the full-stack hold.
module tb_int_ctrl_vec;

  logic        clk_10hz = 1'b0;
  logic        rst = 1'b1;
  logic        rst1 = 1'b1;
  logic [7:0]  irq_in = '0;
  logic [7:0]  irq_mask = 8'hFF;
  logic [2:0]  cpu_state = 3'd0;
  logic [31:0] pc_in = '0;
  logic        ret = 1'b0;

  logic        take, take1;
  logic [31:0] vec_addr, vec1, epc_out, epc1;
  logic [3:0]  active_id, active1;
  logic [2:0]  depth;
  logic [0:0]  depth1;
  logic [7:0]  pending, pending1;
  logic        ret_err, ret_err1;

  int checks = 0;
  int errors = 0;

  always #5 clk_10hz = ~clk_10hz;

  int_ctrl_vec u_dut (
    .clk_10hz (clk_10hz), .rst (rst), .irq_in (irq_in), .irq_mask (irq_mask),
    .cpu_state (cpu_state), .pc_in (pc_in), .ret (ret), .take (take),
    .vec_addr (vec_addr), .epc_out (epc_out), .active_id (active_id),
    .depth (depth), .pending (pending), .ret_err (ret_err)
  );

  int_ctrl_vec #(.NEST_DEPTH(1)) u_dut1 (
    .clk_10hz (clk_10hz), .rst (rst1), .irq_in (irq_in), .irq_mask (irq_mask),
    .cpu_state (cpu_state), .pc_in (pc_in), .ret (ret), .take (take1),
    .vec_addr (vec1), .epc_out (epc1), .active_id (active1),
    .depth (depth1), .pending (pending1), .ret_err (ret_err1)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (main instance, NEST_DEPTH=4) ----------------
  typedef struct { logic [31:0] pc; int id; } frame_t;
  frame_t      m_stack[$];
  frame_t      m_f;
  logic [7:0]  m_pend, m_prev, m_view, m_elig, m_clr;
  int          m_active, m_win, m_w;
  logic [31:0] m_epc, m_vec;
  bit          m_take, m_ack, m_err;

  always @(posedge clk_10hz or posedge rst) begin
    if (rst) begin
      m_stack.delete();
      m_pend = '0; m_prev = '0; m_active = 0; m_win = 0;
      m_epc = '0; m_vec = '0; m_take = 0; m_ack = 0; m_err = 0;
    end else begin
`ifdef INT_CTRL_LEVEL_EN
      m_view = irq_in;
`else
      m_view = m_pend;
`endif
      m_elig = m_view & irq_mask;
      m_w = -1;
      for (int i = 7; i >= 0; i--) if (m_elig[i]) m_w = i;
      m_clr = '0;
      if (ret && m_stack.size() == 0) m_err = 1;
      m_take = 0;
      if (m_ack) begin
        m_f.pc = pc_in; m_f.id = m_active;
        m_stack.push_back(m_f);
        m_active = m_win; m_epc = pc_in; m_clr[m_win] = 1'b1; m_ack = 0;
      end else if (ret && m_stack.size() > 0) begin
        m_f = m_stack.pop_back();
        m_active = m_f.id; m_epc = m_f.pc;
      end else if (!ret && m_w >= 0 && (m_w < m_active || m_stack.size() == 0)
                   && m_stack.size() < 4 && cpu_state == 3'd0) begin
        m_ack = 1; m_take = 1; m_win = m_w;
        m_vec = 32'h40 + 32'(4 * m_w);
      end
      m_pend = (m_pend & ~m_clr) | (irq_in & ~m_prev);
      m_prev = irq_in;
    end
  end

  // Compare the main instance against the model away from the active edge.
  always @(negedge clk_10hz) begin
    if (!rst) begin
      check("take", 64'(take), 64'(m_take));
      check("active_id", 64'(active_id), 64'(m_active));
      check("depth", 64'(depth), 64'(m_stack.size()));
      check("epc_out", 64'(epc_out), 64'(m_epc));
      check("ret_err", 64'(ret_err), 64'(m_err));
`ifdef INT_CTRL_LEVEL_EN
      check("pending", 64'(pending), 64'(irq_in));
`else
      check("pending", 64'(pending), 64'(m_pend));
`endif
      if (m_take) check("vec_addr", 64'(vec_addr), 64'(m_vec));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_10hz);
    #1;
  endtask

  task automatic wait_take(input string nm, input logic [31:0] exp_vec);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!take && n < 40);
    check({nm, " take"}, 64'(take), 64'(1));
    if (take) check({nm, " vec"}, 64'(vec_addr), 64'(exp_vec));
  endtask

  task automatic do_ret();
    ret = 1'b1;
    tick();
    ret = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset take", 64'(take), 64'(0));
    check("reset depth", 64'(depth), 64'(0));
    check("reset vec", 64'(vec_addr), 64'(0));
    check("reset epc", 64'(epc_out), 64'(0));
    check("reset active", 64'(active_id), 64'(0));
    check("reset pending", 64'(pending), 64'(0));
    check("reset ret_err", 64'(ret_err), 64'(0));

`ifdef INT_CTRL_LEVEL_EN
    // Level build: a held source refires after ret.
    pc_in = 32'h100;
    irq_in = 8'h02;
    wait_take("lvl first", 32'h44);
    tick();
    check("lvl active", 64'(active_id), 64'(1));
    check("lvl pending", 64'(pending), 64'h02);
    do_ret();
    check("lvl depth after ret", 64'(depth), 64'(0));
    wait_take("lvl refire", 32'h44);
    tick();
    irq_in = 8'h00;
    do_ret();
    check("lvl pending drop", 64'(pending), 64'(0));
    check("lvl final depth", 64'(depth), 64'(0));
`else
    // Single source.
    pc_in = 32'h100;
    irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    wait_take("single", 32'h4C);
    tick();
    check("single take width", 64'(take), 64'(0));
    check("single active", 64'(active_id), 64'(3));
    check("single depth", 64'(depth), 64'(1));
    check("single pending3", 64'(pending[3]), 64'(0));
    do_ret();
    check("single epc", 64'(epc_out), 64'h100);
    check("single depth ret", 64'(depth), 64'(0));

    // Priority between simultaneous edges.
    irq_in = 8'h24;
    tick();
    irq_in = 8'h00;
    wait_take("prio first", 32'h48);
    tick();
    tick(); tick();
    check("prio held", 64'(take), 64'(0));
    check("prio pending5", 64'(pending[5]), 64'(1));
    do_ret();
    wait_take("prio second", 32'h54);
    tick();
    check("prio second active", 64'(active_id), 64'(5));
    do_ret();

    // Nesting.
    pc_in = 32'h200;
    irq_in = 8'h10;
    tick();
    irq_in = 8'h00;
    wait_take("nest outer", 32'h50);
    tick();
    pc_in = 32'h240;
    irq_in = 8'h02;
    tick();
    irq_in = 8'h00;
    wait_take("nest inner", 32'h44);
    tick();
    check("nest depth2", 64'(depth), 64'(2));
    check("nest active1", 64'(active_id), 64'(1));
    do_ret();
    check("nest epc240", 64'(epc_out), 64'h240);
    check("nest active4", 64'(active_id), 64'(4));
    do_ret();
    check("nest epc200", 64'(epc_out), 64'h200);
    check("nest depth0", 64'(depth), 64'(0));

    // Masked source is retained, then fires once unmasked.
    irq_mask = 8'hBF;
    irq_in = 8'h40;
    tick();
    irq_in = 8'h00;
    repeat (4) tick();
    check("mask no take", 64'(take), 64'(0));
    check("mask pending6", 64'(pending[6]), 64'(1));
    irq_mask = 8'hFF;
    wait_take("unmask", 32'h58);
    tick();
    do_ret();

    // Only take at an instruction boundary.
    cpu_state = 3'd2;
    irq_in = 8'h80;
    tick();
    irq_in = 8'h00;
    repeat (3) begin
      tick();
      check("boundary hold", 64'(take), 64'(0));
    end
    cpu_state = 3'd0;
    wait_take("boundary", 32'h5C);
    tick();
    do_ret();

    // ret with nothing active sets a sticky error.
    do_ret();
    check("ret_err set", 64'(ret_err), 64'(1));
    tick(); tick();
    check("ret_err sticky", 64'(ret_err), 64'(1));

    // Full stack with NEST_DEPTH=1: higher priority waits for ret.
    rst1 = 1'b0;
    irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    tick();
    check("nd1 take", 64'(take1), 64'(1));
    check("nd1 vec", 64'(vec1), 64'h4C);
    tick();
    check("nd1 active", 64'(active1), 64'(3));
    check("nd1 depth", 64'(depth1), 64'(1));
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    repeat (3) begin
      tick();
      check("nd1 full hold", 64'(take1), 64'(0));
    end
    check("nd1 pending0", 64'(pending1), 64'h01);
    do_ret();
    check("nd1 ret no take", 64'(take1), 64'(0));
    tick();
    check("nd1 after ret take", 64'(take1), 64'(1));
    check("nd1 after ret vec", 64'(vec1), 64'h40);
    tick();
    do_ret();

    // Reset in the middle of an ACK cycle.
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    wait_take("pre-reset", 32'h48);
    #2 rst = 1'b1;
    #1;
    check("rst mid-ack take", 64'(take), 64'(0));
    check("rst mid-ack depth", 64'(depth), 64'(0));
    check("rst mid-ack ret_err", 64'(ret_err), 64'(0));
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("post-reset quiet", 64'(take), 64'(0));
`endif

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
